// File: rtl/comb_sweep_ctrl.sv
// Exhaustive 64-vector sweep sequencer for the six-input function unit.
// Optional MISR signature on sig is built only when COMB_SWEEP_SIGNATURE_EN is defined.
`timescale 1ns/1ps
module comb_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] sel,
   input  logic [4:0] y,
   input  logic       ref_in,
   output logic [5:0] vec,
   output logic       busy,
   output logic       done,
   output logic [6:0] ones_cnt,
   output logic [6:0] err_cnt,
   output logic       err_flag,
   output logic [5:0] first_err_vec,
   output logic [15:0] sig
);

   localparam int unsigned VEC_W = 6;
   localparam int unsigned CNT_W = 7;
   localparam int unsigned SET_W = 4;
   localparam int unsigned SEL_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [SET_W-1:0]   set_q, set_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]   ones_q, ones_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic               flag_q, flag_d;
   logic [VEC_W-1:0]   first_q, first_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               s_c;
`ifdef COMB_SWEEP_SIGNATURE_EN
   logic [15:0]        sig_q, sig_d;
`endif

   // State and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         set_q   <= '0;
         sel_q   <= '0;
         ones_q  <= '0;
         err_q   <= '0;
         flag_q  <= 1'b0;
         first_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef COMB_SWEEP_SIGNATURE_EN
         sig_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         set_q   <= set_d;
         sel_q   <= sel_d;
         ones_q  <= ones_d;
         err_q   <= err_d;
         flag_q  <= flag_d;
         first_q <= first_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef COMB_SWEEP_SIGNATURE_EN
         sig_q   <= sig_d;
`endif
      end
   end

   // Next-state and sampling logic
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      set_d   = set_q;
      sel_d   = sel_q;
      ones_d  = ones_q;
      err_d   = err_q;
      flag_d  = flag_q;
      first_d = first_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      s_c     = y[sel_q];
`ifdef COMB_SWEEP_SIGNATURE_EN
      sig_d   = sig_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               sel_d   = (sel > 3'd4) ? 3'd0 : sel;
               vec_d   = '0;
               set_d   = '0;
               ones_d  = '0;
               err_d   = '0;
               flag_d  = 1'b0;
               first_d = '0;
`ifdef COMB_SWEEP_SIGNATURE_EN
               sig_d   = 16'hFFFF;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (set_q != SET_W'(SETTLE_CYCLES)) begin
               set_d = set_q + SET_W'(1);
            end else begin
               ones_d = ones_q + CNT_W'(s_c);
               if (s_c != ref_in) begin
                  err_d = err_q + CNT_W'(1);
                  if (!flag_q) begin
                     flag_d  = 1'b1;
                     first_d = vec_q;
                  end
               end
`ifdef COMB_SWEEP_SIGNATURE_EN
               sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                     ^ {10'b0, y, ref_in};
`endif
               set_d = '0;
               if (vec_q == VEC_W'(63)) begin
                  state_d = DONE;
               end else begin
                  vec_d = vec_q + VEC_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   assign vec           = vec_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign ones_cnt      = ones_q;
   assign err_cnt       = err_q;
   assign err_flag      = flag_q;
   assign first_err_vec = first_q;
`ifdef COMB_SWEEP_SIGNATURE_EN
   assign sig           = sig_q;
`else
   assign sig           = 16'h0000;
`endif

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Bench for comb_sweep_ctrl: two instances (settle 0 and settle 1) driven from
// per-vector lookup tables and checked against a table-walking reference model.
`timescale 1ns/1ps
module tb_comb_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [2:0]  sel;
   logic [4:0]  ytab [64];
   logic        rtab [64];

   logic [5:0]  vec_a, vec_b, fev_a, fev_b;
   logic [4:0]  y_a, y_b;
   logic        ref_a, ref_b;
   logic        busy_a, busy_b, done_a, done_b, flag_a, flag_b;
   logic [6:0]  ones_a, ones_b, err_a, err_b;
   logic [15:0] sig_a, sig_b;

   int          n_chk = 0;
   int          n_bad = 0;
   int          sel_lat;

   always #5 clk = ~clk;

   assign y_a   = ytab[vec_a];
   assign ref_a = rtab[vec_a];
   assign y_b   = ytab[vec_b];
   assign ref_b = rtab[vec_b];

   comb_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel(sel),
      .y(y_a), .ref_in(ref_a), .vec(vec_a), .busy(busy_a), .done(done_a),
      .ones_cnt(ones_a), .err_cnt(err_a), .err_flag(flag_a),
      .first_err_vec(fev_a), .sig(sig_a));

   comb_sweep_ctrl u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel(sel),
      .y(y_b), .ref_in(ref_b), .vec(vec_b), .busy(busy_b), .done(done_b),
      .ones_cnt(ones_b), .err_cnt(err_b), .err_flag(flag_b),
      .first_err_vec(fev_b), .sig(sig_b));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Function unit stand-in: A=v[5] .. F=v[0]; ref_mode 0=same as selected output, 1=one, 2=zero
   task automatic fill_unit(input int rsel, input int ref_mode);
      for (int v = 0; v < 64; v++) begin
         logic a, b, c, d, e, f;
         logic [4:0] yy;
         {a, b, c, d, e, f} = 6'(v);
         yy[0] = (a & b) | (c & d);
         yy[1] = ((a & b & c) | (d & e)) & f;
         yy[2] = a ^ b ^ c;
         yy[3] = d & (~a | b);
         yy[4] = ~(e | f);
         ytab[v] = yy;
         rtab[v] = (ref_mode == 0) ? yy[rsel] : (ref_mode == 1);
      end
   endtask

   task automatic fill_random();
      for (int v = 0; v < 64; v++) begin
         ytab[v] = 5'($urandom);
         rtab[v] = 1'($urandom);
      end
   endtask

   // Reference: walk the first n vectors in order
   task automatic model(input int n, output int ones, output int err, output int flag,
                        output int first, output logic [15:0] sg);
      ones = 0; err = 0; flag = 0; first = 0; sg = 16'hFFFF;
      for (int v = 0; v < n; v++) begin
         logic s;
         s = ytab[v][sel_lat];
         ones += int'(s);
         if (s != rtab[v]) begin
            err++;
            if (flag == 0) begin
               flag = 1;
               first = v;
            end
         end
         sg = {sg[14:0], 1'b0} ^ (sg[15] ? 16'h1021 : 16'h0000) ^ {10'b0, ytab[v], rtab[v]};
      end
   endtask

   task automatic check_res(input string tag, input int n_a, input int n_b);
      int o, e, f, fv;
      logic [15:0] sg, sexp;
      model(n_a, o, e, f, fv, sg);
`ifdef COMB_SWEEP_SIGNATURE_EN
      sexp = sg;
`else
      sexp = 16'h0000;
`endif
      check_val({tag, " a.ones"}, 32'(ones_a), 32'(o));
      check_val({tag, " a.err"},  32'(err_a),  32'(e));
      check_val({tag, " a.flag"}, 32'(flag_a), 32'(f));
      if (f != 0) check_val({tag, " a.first"}, 32'(fev_a), 32'(fv));
      check_val({tag, " a.sig"},  32'(sig_a),  32'(sexp));
      model(n_b, o, e, f, fv, sg);
`ifdef COMB_SWEEP_SIGNATURE_EN
      sexp = sg;
`else
      sexp = 16'h0000;
`endif
      check_val({tag, " b.ones"}, 32'(ones_b), 32'(o));
      check_val({tag, " b.err"},  32'(err_b),  32'(e));
      check_val({tag, " b.flag"}, 32'(flag_b), 32'(f));
      if (f != 0) check_val({tag, " b.first"}, 32'(fev_b), 32'(fv));
      check_val({tag, " b.sig"},  32'(sig_b),  32'(sexp));
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, " zero.a"}, {vec_a, busy_a, done_a, ones_a, err_a, flag_a, fev_a}, 32'd0);
      check_val({tag, " zero.b"}, {vec_b, busy_b, done_b, ones_b, err_b, flag_b, fev_b}, 32'd0);
      check_val({tag, " zero.sig"}, {sig_a, sig_b}, 32'd0);
   endtask

   // Start a sweep with sel s; abort_at=0 runs to completion, else abort after abort_at edges
   task automatic sweep(input string tag, input int s, input int abort_at);
      int t_a, t_b, nd_a, nd_b;
      t_a = -1; t_b = -1; nd_a = 0; nd_b = 0;
      @(negedge clk);
      sel = 3'(s);
      sel_lat = (s > 4) ? 0 : s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sel = 3'($urandom_range(0, 7));
      check_val({tag, " busy_rise"}, 32'({busy_a, busy_b}), 32'd3);
      for (int i = 1; i <= 140; i++) begin
         @(negedge clk);
         if (done_a) begin nd_a++; if (t_a < 0) t_a = i; end
         if (done_b) begin nd_b++; if (t_b < 0) t_b = i; end
         if (abort_at != 0) begin
            if (i == abort_at) abort = 1'b1;
            else if (i == abort_at + 1) begin
               abort = 1'b0;
               check_val({tag, " abort_busy"}, 32'({busy_a, busy_b}), 32'd0);
               break;
            end
         end
      end
      if (abort_at == 0) begin
         check_val({tag, " done_at.a"}, 32'(t_a), 32'd64);
         check_val({tag, " done_at.b"}, 32'(t_b), 32'd128);
         check_val({tag, " done_len"}, 32'(nd_a * 16 + nd_b), 32'd17);
         check_val({tag, " vec_end"}, 32'({vec_a, vec_b}), 32'({6'd63, 6'd63}));
         check_val({tag, " busy_end"}, 32'({busy_a, busy_b}), 32'd0);
         check_res(tag, 64, 64);
      end else begin
         check_val({tag, " no_done"}, 32'(nd_a + nd_b), 32'd0);
         check_res(tag, abort_at, abort_at / 2);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 3'd0; sel_lat = 0;
      fill_random();
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      fill_unit(0, 0);
      sweep("y1_expr", 0, 0);
      check_val("y1_expr ones28", 32'(ones_a), 32'd28);
      check_val("y1_expr err0", 32'(err_a), 32'd0);

      fill_unit(1, 1);
      sweep("y2_one", 1, 0);
      check_val("y2_one ones11", 32'(ones_a), 32'd11);
      check_val("y2_one err53", 32'(err_b), 32'd53);
      check_val("y2_one first0", 32'(fev_a), 32'd0);

      fill_unit(3, 2);
      sweep("y4_zero", 3, 0);
      check_val("y4_zero ones24", 32'(ones_b), 32'd24);
      check_val("y4_zero err24", 32'(err_b), 32'd24);
      check_val("y4_zero first4", 32'(fev_b), 32'd4);

      // Start and abort together in IDLE: no sweep, results hold
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check_val("start_abort busy", 32'({busy_a, busy_b}), 32'd0);
      check_res("start_abort hold", 64, 64);

      fill_random();
      sweep("abort20", $urandom_range(0, 7), 20);
      repeat (3) @(negedge clk);
      check_res("abort20 hold", 20, 10);
      sweep("rerun", $urandom_range(0, 7), 0);

      for (int k = 0; k < 3; k++) begin
         fill_random();
         sweep("rand", $urandom_range(0, 7), 0);
      end

      // Mid-sweep start is ignored, then reset mid-sweep
      fill_random();
      @(negedge clk);
      sel = 3'(2); sel_lat = 2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 30) start = 1'b1;
         if (i == 31) begin
            start = 1'b0;
            check_val("mid_start busy", 32'({busy_a, busy_b}), 32'd3);
            check_val("mid_start vec.a", 32'(vec_a), 32'd31);
            check_res("mid_start cnt", 31, 15);
         end
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_zero("mid_reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_zero("post_reset idle");

      fill_unit(0, 0);
      sweep("y1_rep1", 0, 0);
      sweep("y1_rep2", 0, 0);
`ifdef COMB_SWEEP_SIGNATURE_EN
      check_val("sig_not_seed", 32'(sig_a != 16'hFFFF), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
